// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - 4-way round-robin arbiter with registered grant, ready handshake and timeout.
// Optional grant lock on accept is enabled by defining ARB_LOCK_EN.
module rr_grant_arbiter #(
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       ready,
`ifdef ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic       grant_valid,
    output logic [1:0] grant_idx,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam bit               TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] wait_cnt;

    // First set request bit, scanning upward (mod 4) from the priority pointer.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        pick = p;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) pick = idx;
        end
    endfunction

    logic [1:0] idx_inc;
    logic [1:0] accept_ptr;
    logic       relock;
    logic [1:0] winner_idle;
    logic [1:0] winner_acc;
    logic       expire;

    assign idx_inc = grant_idx + 2'd1;

`ifdef ARB_LOCK_EN
    assign accept_ptr = lock ? ptr : idx_inc;
    assign relock     = lock && req[grant_idx];
`else
    assign accept_ptr = idx_inc;
    assign relock     = 1'b0;
`endif

    assign winner_idle = pick(req, ptr);
    assign winner_acc  = pick(req, accept_ptr);
    assign expire      = TO_EN && (wait_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_idx   <= 2'd0;
            timeout     <= 1'b0;
            ptr         <= 2'd0;
            wait_cnt    <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant_idx   <= winner_idle;
                        grant_valid <= 1'b1;
                        wait_cnt    <= '0;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (ready) begin
                        // Accept wins over an expiring wait in the same cycle.
                        ptr      <= accept_ptr;
                        wait_cnt <= '0;
                        if (relock) begin
                            grant_idx <= grant_idx;
                        end else if (|req) begin
                            grant_idx <= winner_acc;
                        end else begin
                            grant_valid <= 1'b0;
                            state       <= IDLE;
                        end
                    end else if (expire) begin
                        grant_valid <= 1'b0;
                        timeout     <= 1'b1;
                        ptr         <= idx_inc;
                        state       <= IDLE;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb/tb_rr_grant_arbiter.sv - self-checking bench for rr_grant_arbiter against a reference model.
module tb_rr_grant_arbiter;

    localparam int TO = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       ready;
    logic       lock;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    int m_valid, m_idx, m_ptr, m_wait, m_to;

    rr_grant_arbiter #(.TIMEOUT(TO), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .ready      (ready),
`ifdef ARB_LOCK_EN
        .lock       (lock),
`endif
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int winner(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return p;
    endfunction

    task automatic model_update();
        int lk;
        int np;
`ifdef ARB_LOCK_EN
        lk = int'(lock);
`else
        lk = 0;
`endif
        if (rst) begin
            m_valid = 0; m_idx = 0; m_ptr = 0; m_wait = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (m_valid == 0) begin
                if (req != 4'b0) begin
                    m_idx = winner(req, m_ptr); m_valid = 1; m_wait = 0;
                end
            end else if (ready) begin
                np = (lk != 0) ? m_ptr : (m_idx + 1) % 4;
                m_ptr  = np;
                m_wait = 0;
                if (lk != 0 && req[m_idx]) m_idx = m_idx;
                else if (req != 4'b0)      m_idx = winner(req, np);
                else                       m_valid = 0;
            end else if (TO != 0 && m_wait == TO - 1) begin
                m_valid = 0; m_to = 1; m_ptr = (m_idx + 1) % 4;
            end else begin
                m_wait++;
            end
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_update();
        #1;
        check({tag, ".valid"},   int'(grant_valid), m_valid);
        check({tag, ".idx"},     int'(grant_idx),   m_idx);
        check({tag, ".timeout"}, int'(timeout),     m_to);
    endtask

    initial begin
        int vcount;
        rst = 1'b1; req = 4'b1111; ready = 1'b1; lock = 1'b0;
        m_valid = 0; m_idx = 0; m_ptr = 0; m_wait = 0; m_to = 0;

        // Reset held with requests and ready active: outputs stay at reset values.
        for (int i = 0; i < 3; i++) begin
            step("reset");
            check("reset.valid0", int'(grant_valid), 0);
            check("reset.idx0", int'(grant_idx), 0);
        end
        rst = 1'b0;

        // Single request, consumer stalls, then accepts with no further requests.
        req = 4'b0100; ready = 1'b0;
        step("t2.grant");
        check("t2.idx2", int'(grant_idx), 2);
        for (int i = 0; i < 4; i++) step("t2.hold");
        ready = 1'b1; req = 4'b0000;
        step("t2.accept");
        check("t2.released", int'(grant_valid), 0);
        step("t2.idle");

        // Full requests with constant ready: strict rotation from ptr 0.
        rst = 1'b1; step("t3.rst"); rst = 1'b0;
        req = 4'b1111; ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step("t3.rot");
            check("t3.seq", int'(grant_idx), i % 4);
            check("t3.cont", int'(grant_valid), 1);
        end

        // Two requesters alternate; requester 1 never wins twice running.
        rst = 1'b1; step("t4.rst"); rst = 1'b0;
        req = 4'b1010; ready = 1'b1;
        step("t4.first");
        check("t4.first1", int'(grant_idx), 1);
        step("t4.second");
        check("t4.second3", int'(grant_idx), 3);
        step("t4.third");
        check("t4.third1", int'(grant_idx), 1);

        // Timeout: grant visible for exactly TO cycles, then pulse, then regrant.
        rst = 1'b1; step("t5.rst"); rst = 1'b0;
        req = 4'b0001; ready = 1'b0;
        vcount = 0;
        step("t5.grant");
        while (grant_valid === 1'b1 && vcount < 3 * TO) begin
            vcount++;
            step("t5.wait");
        end
        check("t5.valid_cycles", vcount, TO);
        check("t5.pulse", int'(timeout), 1);
        step("t5.regrant");
        check("t5.regrant_idx", int'(grant_idx), 0);
        check("t5.regrant_valid", int'(grant_valid), 1);
        for (int i = 0; i < TO - 2; i++) step("t5.wait2");
        ready = 1'b1; req = 4'b0000;
        step("t5.late_accept");
        check("t5.no_pulse", int'(timeout), 0);
        ready = 1'b0;
        step("t5.after");

        // Reset mid-grant: no pulse, valid drops at the next edge.
        req = 4'b0010;
        step("t7.grant");
        rst = 1'b1;
        step("t7.rst");
        check("t7.rst_valid", int'(grant_valid), 0);
        rst = 1'b0;

`ifdef ARB_LOCK_EN
        req = 4'b1010; ready = 1'b1; lock = 1'b1;
        step("t6.first");
        for (int i = 0; i < 4; i++) begin
            step("t6.lock");
            check("t6.locked1", int'(grant_idx), 1);
        end
        lock = 1'b0;
        step("t6.unlock");
        check("t6.next3", int'(grant_idx), 3);
`endif

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            req   = 4'($urandom_range(0, 15));
            ready = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 39) == 0);
`ifdef ARB_LOCK_EN
            lock  = ($urandom_range(0, 2) == 0);
`endif
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
